// File: rtl/fifo_circ_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, error pulses,
// flush, and a circular replay mode in which each read recirculates the head word to the tail.
module fifo_circ_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       circular,
    input  logic                       flush,
    input  logic                       write,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       read,
    output logic [WIDTH-1:0]           dataout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wr_err,
    output logic                       rd_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic             recirc;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [CW-1:0]    count_nxt;

    // Non-power-of-two depths need an explicit wrap rather than natural overflow.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_comb begin
        rd_ok  = read && !empty;
        recirc = circular && rd_ok;
        // In replay mode an accepted read owns the tail slot, so a same-cycle write loses.
        if (circular)
            wr_ok = write && !rd_ok && !full;
        else
            wr_ok = write && (!full || rd_ok);
        mem_we    = recirc || wr_ok;
        mem_wdata = recirc ? mem[rd_ptr] : datain;
        count_nxt = count;
        if (wr_ok && !(rd_ok && !circular))
            count_nxt = count + CW'(1);
        else if (!wr_ok && rd_ok && !circular)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            dataout <= '0;
            valid   <= 1'b0;
            wr_err  <= 1'b0;
            rd_err  <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid   <= 1'b0;
            wr_err  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            if (rd_ok) begin
                dataout <= mem[rd_ptr];
                rd_ptr  <= ptr_inc(rd_ptr);
            end
            if (mem_we)
                wr_ptr <= ptr_inc(wr_ptr);
            count  <= count_nxt;
            valid  <= rd_ok;
            wr_err <= write && !wr_ok;
            rd_err <= read && empty;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!reset && !flush && mem_we)
            mem[wr_ptr] <= mem_wdata;
    end

endmodule

// File: tb/tb_fifo_circ_param.sv
// Bench for fifo_circ_param: constant vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_fifo_circ_param;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, circular = 1'b0, flush = 1'b0, write = 1'b0, read = 1'b0;
    logic [W-1:0]  datain = '0;
    logic [W-1:0]  dataout;
    logic          valid, full, empty, almost_full, almost_empty, wr_err, rd_err;
    logic [2:0]    count;

    logic          reset5 = 1'b1, write5 = 1'b0, read5 = 1'b0;
    logic [W-1:0]  datain5 = '0;
    logic [W-1:0]  dataout5;
    logic          valid5, full5, empty5, af5, ae5, wr_err5, rd_err5;
    logic [2:0]    count5;

    fifo_circ_param #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .circular(circular), .flush(flush),
        .write(write), .datain(datain), .read(read),
        .dataout(dataout), .valid(valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .wr_err(wr_err), .rd_err(rd_err)
    );

    fifo_circ_param #(.WIDTH(W), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) dut5 (
        .clk(clk), .reset(reset5), .circular(1'b0), .flush(1'b0),
        .write(write5), .datain(datain5), .read(read5),
        .dataout(dataout5), .valid(valid5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5),
        .count(count5), .wr_err(wr_err5), .rd_err(rd_err5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of words.
    logic [31:0] q[$];
    logic [31:0] m_dout = '0;
    logic        m_valid = 1'b0, m_werr = 1'b0, m_rerr = 1'b0;

    task automatic model(input logic r, f, c, w, input logic [31:0] d, input logic rd);
        logic        rd_ok;
        logic [31:0] word;
        if (r) begin
            q.delete(); m_dout = '0; m_valid = 0; m_werr = 0; m_rerr = 0;
        end else if (f) begin
            q.delete(); m_valid = 0; m_werr = 0; m_rerr = 0;
        end else begin
            rd_ok   = rd && (q.size() > 0);
            m_valid = rd_ok;
            m_rerr  = rd && (q.size() == 0);
            m_werr  = 0;
            if (c) begin
                if (rd_ok) begin
                    word = q.pop_front();
                    m_dout = word;
                    q.push_back(word);
                    m_werr = w;
                end else if (w) begin
                    if (q.size() < D) q.push_back(d);
                    else m_werr = 1;
                end
            end else begin
                if (w && !(q.size() < D || rd_ok)) m_werr = 1;
                if (rd_ok) m_dout = q.pop_front();
                if (w && !m_werr) q.push_back(d);
            end
        end
    endtask

    task automatic check_model();
        chk("dataout", dataout, m_dout);
        chk("valid", valid, m_valid);
        chk("wr_err", wr_err, m_werr);
        chk("rd_err", rd_err, m_rerr);
        chk("count", count, q.size());
        chk("full", full, q.size() == D);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= D - 2);
        chk("almost_empty", almost_empty, q.size() <= 1);
    endtask

    task automatic step(input logic r, f, c, w, input logic [31:0] d, input logic rd);
        @(negedge clk);
        reset = r; flush = f; circular = c; write = w; datain = d; read = rd;
        @(posedge clk);
        model(r, f, c, w, d, rd);
        #1;
        check_model();
    endtask

    task automatic step5(input logic r, w, input logic [31:0] d);
        @(negedge clk);
        reset5 = r; write5 = w; datain5 = d; read5 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, c, w, rd;
        logic [31:0] d;
        logic [31:0] dout;
        int          cnt;
        logic        v, werr, rerr;
    } vec_t;

    vec_t vt[8];
    logic [31:0] rep[3];
    logic [31:0] exp_ovf[4];
    logic ae_exp[5], af_exp[5], full_exp[5];

    initial begin
        //            r  c  w  rd  d      dout  cnt v  we re
        vt[0] = '{1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0};
        vt[1] = '{1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0};
        vt[2] = '{0, 0, 1, 0, 32'h9, 32'h0, 1, 0, 0, 0};
        vt[3] = '{0, 0, 1, 0, 32'h1, 32'h0, 2, 0, 0, 0};
        vt[4] = '{0, 0, 0, 0, 32'h0, 32'h0, 2, 0, 0, 0};
        vt[5] = '{0, 0, 0, 1, 32'h0, 32'h9, 1, 1, 0, 0};
        vt[6] = '{0, 0, 0, 1, 32'h0, 32'h1, 0, 1, 0, 0};
        vt[7] = '{0, 0, 0, 1, 32'h0, 32'h1, 0, 0, 0, 1};
        rep = '{32'h9, 32'h1, 32'h47F};
        exp_ovf = '{32'hB, 32'hC, 32'hD, 32'hF};
        ae_exp   = '{1, 0, 0, 0, 0};
        af_exp   = '{0, 0, 1, 1, 1};
        full_exp = '{0, 0, 0, 0, 1};

        // Thresholds on the DEPTH=5 instance while the main instance sits in reset.
        step5(1, 0, 0);
        chk("t5_reset_count", count5, 0);
        chk("t5_reset_ae", ae5, 1);
        chk("t5_reset_af", af5, 0);
        for (int k = 0; k < 5; k++) begin
            step5(0, 1, 32'h100 + k);
            chk("t5_count", count5, k + 1);
            chk("t5_almost_empty", ae5, ae_exp[k]);
            chk("t5_almost_full", af5, af_exp[k]);
            chk("t5_full", full5, full_exp[k]);
        end
        step5(0, 1, 32'hDEAD);
        chk("t5_overflow_wr_err", wr_err5, 1);
        chk("t5_overflow_count", count5, 5);
        step5(1, 0, 0);

        // Basic ordering from the vector table.
        for (int i = 0; i < 8; i++) begin
            step(vt[i].r, 0, vt[i].c, vt[i].w, vt[i].d, vt[i].rd);
            chk("vec_dataout", dataout, vt[i].dout);
            chk("vec_count", count, vt[i].cnt);
            chk("vec_valid", valid, vt[i].v);
            chk("vec_wr_err", wr_err, vt[i].werr);
            chk("vec_rd_err", rd_err, vt[i].rerr);
        end
        chk("vec_empty_end", empty, 1);

        // Circular replay.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rep[i], 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 0, 0, 1);
            chk("replay_data", dataout, rep[i % 3]);
            chk("replay_valid", valid, 1);
            chk("replay_count", count, 3);
        end
        // Read+write conflict in replay: the write loses, replay continues.
        step(0, 0, 1, 1, 32'h0, 1);
        chk("conflict_wr_err", wr_err, 1);
        chk("conflict_data", dataout, 32'h9);
        chk("conflict_count", count, 3);
        step(0, 0, 1, 1, 32'h0, 0);
        chk("replay_fill_count", count, 4);
        chk("replay_fill_full", full, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 1);
        chk("replay_includes_zero", dataout, 32'h0);
        chk("replay_full_count", count, 4);

        // Overflow and full-boundary read+write.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'hA + i, 0);
        chk("ovf_wr_err", wr_err, 1);
        chk("ovf_count", count, 4);
        chk("ovf_full", full, 1);
        chk("ovf_almost_full", almost_full, 1);
        step(0, 0, 0, 1, 32'hF, 1);
        chk("fullrw_data", dataout, 32'hA);
        chk("fullrw_count", count, 4);
        chk("fullrw_wr_err", wr_err, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("ovf_drain", dataout, exp_ovf[i]);
        end

        // Flush with simultaneous read/write, then reuse, then reset mid-burst.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h20 + i, 0);
        step(0, 1, 0, 1, 32'h77, 1);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", valid, 0);
        chk("flush_errs", {wr_err, rd_err}, 0);
        chk("flush_dout_held", dataout, 32'hF);
        step(0, 0, 0, 1, 32'h55, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("post_flush_data", dataout, 32'h55);
        step(0, 0, 0, 1, 32'h61, 0);
        step(0, 0, 0, 1, 32'h62, 1);
        step(1, 0, 0, 1, 32'h63, 1);
        chk("midreset_dout", dataout, 0);
        chk("midreset_count", count, 0);
        step(0, 0, 0, 1, 32'h70, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("post_reset_data", dataout, 32'h70);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0,
                 (i / 200) % 2 == 1 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 40), $urandom,
                 $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
